// File: rtl/systolic_pe.sv
// Weight-stationary systolic processing element: holds one weight, MACs it against
// each valid activation into the incoming partial sum, and forwards the activation right.
module systolic_pe #(
  parameter int DATA_W = 8,
  parameter int PSUM_W = 24,
  parameter int SIGNED = 0
) (
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              weight_valid,
  input  logic [DATA_W-1:0] weights,
  input  logic              in_data_valid,
  input  logic [DATA_W-1:0] in_raw_data,
  output logic              out_data_valid,
  output logic [DATA_W-1:0] out_raw_data,
  input  logic [PSUM_W-1:0] in_psum_data,
  output logic [PSUM_W-1:0] out_psum_data
);

  localparam int PROD_W = 2 * DATA_W;

  logic [DATA_W-1:0] r_weight;
  logic              r_data_valid;
  logic [DATA_W-1:0] r_raw_data;
  logic [PSUM_W-1:0] r_psum;

  logic [PROD_W-1:0] w_prod;
  logic [PSUM_W-1:0] w_prod_ext;
  logic [PSUM_W-1:0] w_sum;

  // Operands are widened to the full product width before multiplying so the
  // result is exact; sign handling is chosen at elaboration time.
  generate
    if (SIGNED != 0) begin : g_signed
      assign w_prod     = PROD_W'($signed(in_raw_data)) * PROD_W'($signed(r_weight));
      assign w_prod_ext = PSUM_W'($signed(w_prod));
    end else begin : g_unsigned
      assign w_prod     = PROD_W'(in_raw_data) * PROD_W'(r_weight);
      assign w_prod_ext = PSUM_W'(w_prod);
    end
  endgenerate

  // Wraps modulo 2^PSUM_W by construction.
  assign w_sum = in_psum_data + w_prod_ext;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; that is what makes the MAC in a load cycle see the OLD weight.
  always_ff @(posedge s_clk or negedge s_rst) begin
    if (!s_rst) begin
      r_weight     <= '0;
      r_data_valid <= 1'b0;
      r_raw_data   <= '0;
      r_psum       <= '0;
    end else begin
      r_data_valid <= in_data_valid;
      if (weight_valid) begin
        r_weight <= weights;
      end
      if (in_data_valid) begin
        r_raw_data <= in_raw_data;
        r_psum     <= w_sum;
      end
    end
  end

  assign out_data_valid = r_data_valid;
  assign out_raw_data   = r_raw_data;
  assign out_psum_data  = r_psum;

endmodule

// File: tb/tb_systolic_pe.sv
// Scoreboard bench for systolic_pe: unsigned and signed instances share stimulus;
// a driver pushes model results, a negedge monitor pops and compares them.
module tb_systolic_pe;

  localparam int DW = 8;
  localparam int PW = 24;

  typedef struct {
    logic [DW-1:0] raw;
    logic [PW-1:0] psum_u;
    logic [PW-1:0] psum_s;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          weight_valid = 1'b0;
  logic [DW-1:0] weights = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_raw = '0;
  logic [PW-1:0] in_psum = '0;

  logic          ov_u, ov_s;
  logic [DW-1:0] or_u, or_s;
  logic [PW-1:0] op_u, op_s;

  exp_t          sb_q[$];
  exp_t          last_exp;
  logic [DW-1:0] w_model = '0;
  int            n_vec = 0;
  int            n_fail = 0;

  systolic_pe #(.DATA_W(DW), .PSUM_W(PW), .SIGNED(0)) u_pe_u (
    .s_clk(clk), .s_rst(rst_n), .weight_valid(weight_valid), .weights(weights),
    .in_data_valid(in_valid), .in_raw_data(in_raw), .out_data_valid(ov_u),
    .out_raw_data(or_u), .in_psum_data(in_psum), .out_psum_data(op_u)
  );

  systolic_pe #(.DATA_W(DW), .PSUM_W(PW), .SIGNED(1)) u_pe_s (
    .s_clk(clk), .s_rst(rst_n), .weight_valid(weight_valid), .weights(weights),
    .in_data_valid(in_valid), .in_raw_data(in_raw), .out_data_valid(ov_s),
    .out_raw_data(or_s), .in_psum_data(in_psum), .out_psum_data(op_s)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic in plain integers, truncated to the psum width.
  function automatic logic [PW-1:0] mac_u(input logic [PW-1:0] p, input logic [DW-1:0] d,
                                          input logic [DW-1:0] w);
    longint acc;
    acc = longint'(d) * longint'(w) + longint'(p);
    return acc[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] mac_s(input logic [PW-1:0] p, input logic [DW-1:0] d,
                                          input logic [DW-1:0] w);
    longint acc;
    acc = longint'($signed(d)) * longint'($signed(w)) + longint'($signed(p));
    return acc[PW-1:0];
  endfunction

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [PW-1:0] p,
                       input logic wv, input logic [DW-1:0] w);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid     = v;
    in_raw       = d;
    in_psum      = p;
    weight_valid = wv;
    weights      = w;
    if (rst_n && v) begin
      e.raw    = d;
      e.psum_u = mac_u(p, d, w_model);
      e.psum_s = mac_s(p, d, w_model);
      sb_q.push_back(e);
    end
    if (rst_n && wv) w_model = w;
  endtask

  task automatic idle();
    drive(1'b0, DW'($urandom), PW'($urandom), 1'b0, DW'($urandom));
  endtask

  task automatic apply_reset(input int cycles);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb_q.delete();
    w_model = '0;
    for (int i = 0; i < cycles; i++) begin
      drive($urandom_range(0, 1), DW'($urandom), PW'($urandom),
            $urandom_range(0, 1), DW'($urandom));
    end
    @(posedge clk);
    #1;
    in_valid     = 1'b0;
    weight_valid = 1'b0;
    rst_n        = 1'b1;
  endtask

  // Monitor: zeros under reset, pop on valid output, otherwise outputs must hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      check("rst_valid_u", 32'(ov_u), 32'd0);
      check("rst_valid_s", 32'(ov_s), 32'd0);
      check("rst_raw_u", 32'(or_u), 32'd0);
      check("rst_psum_u", 32'(op_u), 32'd0);
      check("rst_psum_s", 32'(op_s), 32'd0);
      last_exp = '{raw: '0, psum_u: '0, psum_s: '0};
    end else if (ov_u) begin
      check("valid_s_tracks_u", 32'(ov_s), 32'd1);
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'(ov_u), 32'd0);
      end else begin
        e = sb_q.pop_front();
        check("raw_u", 32'(or_u), 32'(e.raw));
        check("raw_s", 32'(or_s), 32'(e.raw));
        check("psum_u", 32'(op_u), 32'(e.psum_u));
        check("psum_s", 32'(op_s), 32'(e.psum_s));
        last_exp = e;
      end
    end else begin
      check("idle_valid_s", 32'(ov_s), 32'd0);
      check("hold_raw_u", 32'(or_u), 32'(last_exp.raw));
      check("hold_psum_u", 32'(op_u), 32'(last_exp.psum_u));
      check("hold_psum_s", 32'(op_s), 32'(last_exp.psum_s));
    end
  end

  initial begin
    last_exp = '{raw: '0, psum_u: '0, psum_s: '0};
    apply_reset(4);
    repeat (2) idle();

    // Load weight 1, single datum 1 with zero psum.
    drive(1'b0, 8'd0, 24'd0, 1'b1, 8'd1);
    drive(1'b1, 8'd1, 24'd0, 1'b0, 8'd0);
    idle();
    check("load_mac_valid", 32'(ov_u), 32'd1);
    check("load_mac_raw", 32'(or_u), 32'd1);
    check("load_mac_psum", 32'(op_u), 32'd1);
    idle();
    check("load_mac_valid_drop", 32'(ov_u), 32'd0);
    check("load_mac_psum_hold", 32'(op_u), 32'd1);

    // Weight update in the same cycle as data uses the old weight.
    drive(1'b1, 8'd2, 24'd0, 1'b1, 8'd5);
    drive(1'b1, 8'd2, 24'd0, 1'b0, 8'd0);
    check("collide_old_weight", 32'(op_u), 32'd2);
    idle();
    check("collide_new_weight", 32'(op_u), 32'd10);

    // Unsigned wrap, and signed view of the same bits.
    drive(1'b0, 8'd0, 24'd0, 1'b1, 8'd255);
    drive(1'b1, 8'd255, 24'hFFFFFF, 1'b0, 8'd0);
    idle();
    check("wrap_unsigned", 32'(op_u), 32'h00FE00);
    check("wrap_signed", 32'(op_s), 32'h000000);

    // Signed -3 * 4.
    drive(1'b0, 8'd0, 24'd0, 1'b1, 8'd4);
    drive(1'b1, 8'hFD, 24'd0, 1'b0, 8'd0);
    idle();
    check("signed_neg", 32'(op_s), 32'hFFFFF4);
    check("signed_as_unsigned", 32'(op_u), 32'h0003F4);

    // Eight back-to-back valid data.
    drive(1'b0, 8'd0, 24'd0, 1'b1, DW'($urandom));
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, DW'($urandom), PW'($urandom), 1'b0, 8'd0);
    end
    repeat (2) idle();

    // Randomized traffic with occasional weight reloads and resets.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        apply_reset($urandom_range(1, 3));
      end else begin
        drive($urandom_range(0, 3) != 0, DW'($urandom), PW'($urandom),
              $urandom_range(0, 7) == 0, DW'($urandom));
      end
    end
    repeat (3) idle();
    @(negedge clk);
    check("queue_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
